// File: rtl/uart_pkg.sv
// Shared UART transmitter constants and a counter-width helper.
package uart_pkg;

  // Counter widths for the UART transmitter's bit counters.
  localparam int UART_DATA_CNT_W = 4;
  localparam int UART_STOP_CNT_W = 2;

  // Default terminal values for the data-bit and stop-bit counters.
  localparam int UART_DATA_CNT_MAX = 15;
  localparam int UART_STOP_CNT_MAX = 3;

  // Smallest counter width that can hold max_val (never less than 1 bit).
  function automatic int cnt_width(input int unsigned max_val);
    int w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if (max_val >= (32'd1 << i)) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Free-running modulo (MAX_VAL+1) up-counter with count enable and
// asynchronous active-low clear. Parent FSMs compare out against a runtime
// target and pulse rst to restart from zero.
module mod_counter
  import uart_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MAX_VAL = (1 << WIDTH) - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  output logic [WIDTH-1:0] out,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);

  // Reject illegal parameterisations at elaboration time.
  if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
    $error("mod_counter: WIDTH=%0d outside 1..16", WIDTH);
  end
  if (MAX_VAL < 0 || cnt_width(MAX_VAL) > WIDTH) begin : g_bad_max
    $error("mod_counter: MAX_VAL=%0d does not fit in %0d bits", MAX_VAL, WIDTH);
  end

  // Count register: async clear, hold when disabled, wrap after MAX_VAL.
  // Using >= also recovers from any out-of-range value on the next enabled edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out <= '0;
    end else if (ce) begin
      if (out >= MAX_Q) out <= '0;
      else              out <= out + 1'b1;
    end
  end

  // Terminal count decoded straight from the register, independent of ce.
  assign tc = (out == MAX_Q);

endmodule

// File: tb/tb_mod_counter.sv
// Scoreboard bench for mod_counter: three parameterisations share one clock.
module tb_mod_counter;
  import uart_pkg::*;

  logic clk;
  logic rst_a, rst_b, rst_c;
  logic ce_a, ce_b, ce_c;
  logic [UART_DATA_CNT_W-1:0] out_a;
  logic [UART_STOP_CNT_W-1:0] out_b;
  logic [3:0]                 out_c;
  logic tc_a, tc_b, tc_c;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string tag;
    int    out;
    int    tc;
  } exp_t;

  exp_t exp_q[$];
  int   mdl[3];
  int   maxv[3];

  mod_counter #(.WIDTH(UART_DATA_CNT_W)) u_a (
    .clk(clk), .rst(rst_a), .ce(ce_a), .out(out_a), .tc(tc_a)
  );
  mod_counter #(.WIDTH(UART_STOP_CNT_W), .MAX_VAL(UART_STOP_CNT_MAX)) u_b (
    .clk(clk), .rst(rst_b), .ce(ce_b), .out(out_b), .tc(tc_b)
  );
  mod_counter #(.WIDTH(4), .MAX_VAL(9)) u_c (
    .clk(clk), .rst(rst_c), .ce(ce_c), .out(out_c), .tc(tc_c)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int get_out(input int sel);
    case (sel)
      0:       return int'(out_a);
      1:       return int'(out_b);
      default: return int'(out_c);
    endcase
  endfunction

  function automatic int get_tc(input int sel);
    case (sel)
      0:       return int'(tc_a);
      1:       return int'(tc_b);
      default: return int'(tc_c);
    endcase
  endfunction

  function automatic logic get_rst(input int sel);
    case (sel)
      0:       return rst_a;
      1:       return rst_b;
      default: return rst_c;
    endcase
  endfunction

  // Drive ce on one counter for one edge, predict, then compare after the edge.
  task automatic step(input int sel, input logic c, input string tag);
    exp_t e;
    @(negedge clk);
    case (sel)
      0:       ce_a = c;
      1:       ce_b = c;
      default: ce_c = c;
    endcase
    if (!get_rst(sel))      mdl[sel] = 0;
    else if (c)             mdl[sel] = (mdl[sel] >= maxv[sel]) ? 0 : mdl[sel] + 1;
    e.tag = tag;
    e.out = mdl[sel];
    e.tc  = (mdl[sel] == maxv[sel]) ? 1 : 0;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({e.tag, "_out"}, get_out(sel), e.out);
    chk({e.tag, "_tc"},  get_tc(sel),  e.tc);
  endtask

  initial begin
    int n;
    maxv[0] = UART_DATA_CNT_MAX;
    maxv[1] = UART_STOP_CNT_MAX;
    maxv[2] = 9;
    foreach (mdl[i]) mdl[i] = 0;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    ce_a  = 1'b1; ce_b  = 1'b1; ce_c  = 1'b1;

    // Reset state: clock running with ce high, outputs must stay cleared.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_a", int'(out_a), 0);
    chk("rst_out_b", int'(out_b), 0);
    chk("rst_out_c", int'(out_c), 0);
    chk("rst_tc_a", int'(tc_a), 0);
    chk("rst_tc_b", int'(tc_b), 0);
    chk("rst_tc_c", int'(tc_c), 0);
    @(negedge clk);
    ce_a = 1'b0; ce_b = 1'b0; ce_c = 1'b0;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;

    // Async reset: count to 5, clear between edges, hold through 3 enabled edges.
    for (int i = 0; i < 5; i++) step(0, 1'b1, "cnt5");
    @(negedge clk);
    rst_a = 1'b0;
    mdl[0] = 0;
    #1;
    chk("async_clear_out", int'(out_a), 0);
    for (int i = 0; i < 3; i++) step(0, 1'b1, "rst_hold");
    @(negedge clk);
    ce_a  = 1'b0;
    rst_a = 1'b1;

    // Enable gating: ce 1,0,1,1,0 -> out 1,1,2,3,3.
    step(0, 1'b1, "gate0");
    step(0, 1'b0, "gate1");
    step(0, 1'b1, "gate2");
    step(0, 1'b1, "gate3");
    step(0, 1'b0, "gate4");

    // Target compare: out==8 reached exactly 8 enabled edges after release.
    @(negedge clk);
    rst_a = 1'b0;
    @(negedge clk);
    rst_a = 1'b1;
    ce_a  = 1'b1;
    n = 21;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (out_a == 4'd8) begin
        n = i;
        break;
      end
    end
    chk("target_edges", n, 8);
    mdl[0] = 8;
    // Continue to the natural top value and across the wrap.
    for (int i = 0; i < 9; i++) step(0, 1'b1, "wrap16");

    // Full wrap on the 2-bit counter: 1,2,3,0,1,2.
    for (int i = 0; i < 6; i++) step(1, 1'b1, "wrap4");

    // Custom modulus: 1..9, then 0,1,2.
    for (int i = 0; i < 12; i++) step(2, 1'b1, "mod10");

    // Reset falls exactly on an enabled rising edge: clear must win.
    @(negedge clk);
    ce_c = 1'b1;
    #5;
    rst_c = 1'b0;
    mdl[2] = 0;
    #1;
    chk("rst_vs_ce_out", int'(out_c), 0);
    @(posedge clk);
    #1;
    chk("rst_vs_ce_hold", int'(out_c), 0);
    @(negedge clk);
    ce_c  = 1'b0;
    rst_c = 1'b1;
    step(2, 1'b1, "after_rst");
    step(2, 1'b0, "after_hold");

    chk("sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
